// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU: instruction field layout,
// special opcodes and the fetch/halt state encoding.
package cpu19_pkg;

    localparam int INSTR_W = 19;

    // Instruction field bit positions
    localparam int OP_HI  = 18;
    localparam int OP_LO  = 14;
    localparam int RS_HI  = 13;
    localparam int RS_LO  = 11;
    localparam int RT_HI  = 10;
    localparam int RT_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [4:0] NOP_OP  = 5'b00000;
    localparam logic [4:0] HALT_OP = 5'b11111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } cpu_state_e;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// r0 is hardwired zero, so a load targeting it never blocks a consumer.
module hazard_unit #(
    parameter logic [4:0] NOP_OP  = cpu19_pkg::NOP_OP,
    parameter logic [4:0] HALT_OP = cpu19_pkg::HALT_OP
) (
    input  logic       ex_memread_i,
    input  logic [2:0] ex_rt_i,
    input  logic [2:0] id_rs_i,
    input  logic [2:0] id_rt_i,
    input  logic [4:0] id_opcode_i,
    input  logic       id_valid_i,
    output logic       stall_o
);
    import cpu19_pkg::*;

    logic reg_match;
    logic real_op;

    // Stall when the ID instruction reads the register a load in EX is writing
    always_comb begin
        reg_match = (ex_rt_i != 3'd0) && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
        real_op   = (id_opcode_i != NOP_OP) && (id_opcode_i != HALT_OP);
        stall_o   = ex_memread_i && id_valid_i && reg_match && real_op;
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC, instruction latch, branch
// flush, load-use stall and HALT handling, plus the decoded ID fields.
module if_id_stage #(
    parameter int         PC_W    = 16,
    parameter logic [4:0] HALT_OP = cpu19_pkg::HALT_OP,
    parameter logic [4:0] NOP_OP  = cpu19_pkg::NOP_OP
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [18:0]     imem_data,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            EX_memread,
    input  logic [2:0]      EX_rt,
    output logic [4:0]      ID_opcode,
    output logic [2:0]      ID_rs,
    output logic [2:0]      ID_rt,
    output logic [2:0]      ID_rd,
    output logic [7:0]      ID_immediate,
    output logic [PC_W-1:0] ID_pc,
    output logic            ID_valid,
    output logic            stall,
    output logic            id_bubble,
    output logic            halted,
    output logic [15:0]     stall_count
);
    import cpu19_pkg::*;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;
    cpu_state_e         state_q, state_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic               hazard;
    logic               halt_det;

    // Field decode straight off the IF/ID register; rd and immediate overlap
    always_comb begin
        ID_opcode    = instr_q[OP_HI:OP_LO];
        ID_rs        = instr_q[RS_HI:RS_LO];
        ID_rt        = instr_q[RT_HI:RT_LO];
        ID_rd        = instr_q[RD_HI:RD_LO];
        ID_immediate = instr_q[IMM_HI:IMM_LO];
    end

    hazard_unit #(
        .NOP_OP  (NOP_OP),
        .HALT_OP (HALT_OP)
    ) u_hazard (
        .ex_memread_i (EX_memread),
        .ex_rt_i      (EX_rt),
        .id_rs_i      (ID_rs),
        .id_rt_i      (ID_rt),
        .id_opcode_i  (ID_opcode),
        .id_valid_i   (id_valid_q),
        .stall_o      (hazard)
    );

    // Status outputs; nothing stalls once fetch has halted
    always_comb begin
        halt_det    = id_valid_q && (ID_opcode == HALT_OP);
        stall       = hazard && (state_q == RUN);
        halted      = (state_q == HALTED);
        id_bubble   = stall || !id_valid_q || halted;
        imem_addr   = pc_q;
        ID_pc       = id_pc_q;
        ID_valid    = id_valid_q;
        stall_count = stall_cnt_q;
    end

    // Next state: flush beats stall beats halt beats normal fetch
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == RUN) begin
            if (br_taken) begin
                pc_d       = br_target;
                instr_d    = '0;
                id_valid_d = 1'b0;
            end else if (hazard) begin
                if (stall_cnt_q != 16'hFFFF)
                    stall_cnt_d = stall_cnt_q + 16'd1;
            end else if (halt_det) begin
                instr_d    = '0;
                id_valid_d = 1'b0;
                state_d    = HALTED;
            end else begin
                instr_d    = imem_data;
                id_pc_d    = pc_q;
                id_valid_d = 1'b1;
                pc_d       = pc_q + PC_W'(1);
            end
        end else begin
            id_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            instr_q     <= '0;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: expected IF/ID state is queued as each
// step is driven and popped after the clock edge that should produce it.
module tb_if_id_stage;
    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] imem_addr;
    logic [18:0]     imem_data;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            EX_memread;
    logic [2:0]      EX_rt;
    logic [4:0]      ID_opcode;
    logic [2:0]      ID_rs, ID_rt, ID_rd;
    logic [7:0]      ID_immediate;
    logic [PC_W-1:0] ID_pc;
    logic            ID_valid, stall, id_bubble, halted;
    logic [15:0]     stall_count;

    logic [18:0] mem [0:255];

    typedef struct {
        logic        v;
        logic [15:0] idpc;
        logic [4:0]  op;
        logic [15:0] addr;
        logic        hlt;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    if_id_stage #(.PC_W(PC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .EX_memread   (EX_memread),
        .EX_rt        (EX_rt),
        .ID_opcode    (ID_opcode),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_rd        (ID_rd),
        .ID_immediate (ID_immediate),
        .ID_pc        (ID_pc),
        .ID_valid     (ID_valid),
        .stall        (stall),
        .id_bubble    (id_bubble),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [7:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic v, input logic [15:0] idpc, input logic [4:0] op,
                            input logic [15:0] addr, input logic hlt, input logic [15:0] sc);
        exp_t e;
        e.v = v; e.idpc = idpc; e.op = op; e.addr = addr; e.hlt = hlt; e.sc = sc;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 32'(ID_valid), 32'(e.v));
            if (e.v) chk({tag, ".id_pc"}, 32'(ID_pc), 32'(e.idpc));
            chk({tag, ".opcode"}, 32'(ID_opcode), 32'(e.op));
            chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(e.addr));
            chk({tag, ".halted"}, 32'(halted), 32'(e.hlt));
            chk({tag, ".stall_count"}, 32'(stall_count), 32'(e.sc));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = mk(5'h0A, 3'd0, 3'd0, 8'h00);
        mem[0]     = 19'h08A00;
        mem[1]     = 19'h10B20;
        mem[2]     = 19'h18C40;
        mem[3]     = mk(5'h01, 3'd3, 3'd5, 8'h00);
        mem[4]     = mk(5'h03, 3'd3, 3'd1, 8'h00);
        mem[8'h40] = mk(5'h05, 3'd0, 3'd0, 8'h11);
        mem[8'hFF] = mk(5'h07, 3'd0, 3'd0, 8'h00);

        rst = 1'b1; br_taken = 1'b0; br_target = '0; EX_memread = 1'b0; EX_rt = 3'd0;

        // Reset state
        tick();
        push_exp(0, 16'h0, 5'h00, 16'h0, 0, 16'h0); step("reset");
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.bubble", 32'(id_bubble), 32'd1);
        rst = 1'b0;

        // Sequential fetch
        push_exp(1, 16'h0, 5'h02, 16'h1, 0, 16'h0); step("f0");
        push_exp(1, 16'h1, 5'h04, 16'h2, 0, 16'h0); step("f1");
        chk("f1.rs", 32'(ID_rs), 32'd1);
        chk("f1.rt", 32'(ID_rt), 32'd3);
        chk("f1.rd", 32'(ID_rd), 32'd1);
        chk("f1.imm", 32'(ID_immediate), 32'h20);
        push_exp(1, 16'h2, 5'h06, 16'h3, 0, 16'h0); step("f2");
        push_exp(1, 16'h3, 5'h01, 16'h4, 0, 16'h0); step("f3");
        chk("f3.rs", 32'(ID_rs), 32'd3);
        chk("f3.bubble", 32'(id_bubble), 32'd0);

        // Load-use stall: one cycle hold
        EX_memread = 1'b1; EX_rt = 3'd3; #1;
        chk("lu.stall", 32'(stall), 32'd1);
        chk("lu.bubble", 32'(id_bubble), 32'd1);
        push_exp(1, 16'h3, 5'h01, 16'h4, 0, 16'h1); step("lu_hold");
        EX_rt = 3'd0; #1;
        chk("lu_r0.stall", 32'(stall), 32'd0);
        chk("lu_r0.bubble", 32'(id_bubble), 32'd0);
        EX_rt = 3'd5; #1;
        chk("lu_rt.stall", 32'(stall), 32'd1);
        EX_memread = 1'b0; #1;
        chk("lu_noload.stall", 32'(stall), 32'd0);
        push_exp(1, 16'h4, 5'h03, 16'h5, 0, 16'h1); step("lu_resume");

        // Branch flush with a simultaneous stall: flush wins, no count
        br_taken = 1'b1; br_target = 16'h0040; EX_memread = 1'b1; EX_rt = 3'd3; #1;
        chk("brst.stall", 32'(stall), 32'd1);
        push_exp(0, 16'h0, 5'h00, 16'h40, 0, 16'h1); step("br_flush");
        br_taken = 1'b0; EX_memread = 1'b0; EX_rt = 3'd0; #1;
        chk("br_flush.bubble", 32'(id_bubble), 32'd1);
        push_exp(1, 16'h40, 5'h05, 16'h41, 0, 16'h1); step("br_tgt");
        chk("br_tgt.imm", 32'(ID_immediate), 32'h11);

        // PC wraps modulo 2^PC_W
        br_taken = 1'b1; br_target = 16'hFFFF;
        push_exp(0, 16'h0, 5'h00, 16'hFFFF, 0, 16'h1); step("br_wrap");
        br_taken = 1'b0;
        push_exp(1, 16'hFFFF, 5'h07, 16'h0, 0, 16'h1); step("wrap");

        // Halt, including a flush that cancels the halt
        mem[3] = 19'h7C000;
        rst = 1'b1;
        push_exp(0, 16'h0, 5'h00, 16'h0, 0, 16'h0); step("rst2");
        rst = 1'b0;
        push_exp(1, 16'h0, 5'h02, 16'h1, 0, 16'h0); step("h_f0");
        push_exp(1, 16'h1, 5'h04, 16'h2, 0, 16'h0); step("h_f1");
        push_exp(1, 16'h2, 5'h06, 16'h3, 0, 16'h0); step("h_f2");
        push_exp(1, 16'h3, 5'h1F, 16'h4, 0, 16'h0); step("h_inid");
        chk("h_inid.bubble", 32'(id_bubble), 32'd0);
        br_taken = 1'b1; br_target = 16'h0003;
        push_exp(0, 16'h0, 5'h00, 16'h3, 0, 16'h0); step("halt_flush");
        br_taken = 1'b0;
        push_exp(1, 16'h3, 5'h1F, 16'h4, 0, 16'h0); step("halt_refetch");
        push_exp(0, 16'h0, 5'h00, 16'h4, 1, 16'h0); step("halt_enter");
        chk("halt_enter.bubble", 32'(id_bubble), 32'd1);
        br_taken = 1'b1; br_target = 16'h0020; EX_memread = 1'b1; EX_rt = 3'd0; #1;
        chk("halt.stall", 32'(stall), 32'd0);
        push_exp(0, 16'h0, 5'h00, 16'h4, 1, 16'h0); step("halt_br_ign");
        push_exp(0, 16'h0, 5'h00, 16'h4, 1, 16'h0); step("halt_hold");
        br_taken = 1'b0; EX_memread = 1'b0;
        rst = 1'b1;
        push_exp(0, 16'h0, 5'h00, 16'h0, 0, 16'h0); step("halt_rst");
        rst = 1'b0;

        // Saturating stall counter, then reset mid-stall
        mem[0] = mk(5'h01, 3'd2, 3'd0, 8'h00);
        push_exp(1, 16'h0, 5'h01, 16'h1, 0, 16'h0); step("sat_f0");
        EX_memread = 1'b1; EX_rt = 3'd2;
        repeat (65533) tick();
        push_exp(1, 16'h0, 5'h01, 16'h1, 0, 16'hFFFE); step("sat_fffe");
        push_exp(1, 16'h0, 5'h01, 16'h1, 0, 16'hFFFF); step("sat_ffff");
        push_exp(1, 16'h0, 5'h01, 16'h1, 0, 16'hFFFF); step("sat_hold");
        chk("sat.stall", 32'(stall), 32'd1);
        rst = 1'b1;
        push_exp(0, 16'h0, 5'h00, 16'h0, 0, 16'h0); step("rst_mid_stall");
        rst = 1'b0; EX_memread = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
